// File: rtl/cj_host_uart_monitor_if.sv
// Harness-side bundle for the host monitor: tohost status port plus the UART pins.
// The harness/bench owns the master side, the monitor owns the slave side.
interface cj_host_uart_monitor_if;
    logic        tohost_wr_en;
    logic [63:0] tohost_wr_data;
    logic        tohost_clr;
    logic [63:0] tohost;
    logic        srx;
    logic        stx;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        frame_err;
    logic        tx_drop;

    modport master (
        output tohost_wr_en, tohost_wr_data, tohost_clr, srx,
        input  tohost, stx, rx_valid, rx_data, frame_err, tx_drop
    );

    modport slave (
        input  tohost_wr_en, tohost_wr_data, tohost_clr, srx,
        output tohost, stx, rx_valid, rx_data, frame_err, tx_drop
    );
endinterface

// File: rtl/cj_host_uart_monitor.sv
// Host monitor: 64-bit tohost status register plus a UART receiver with optional
// echo transmitter. The tohost and UART halves share only clock and reset.
module cj_host_uart_monitor #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int LOOPBACK    = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    cj_host_uart_monitor_if.slave        bus
);
    localparam int DIV_RAW = CLK_FREQ_HZ / BAUD;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int HALF    = DIV / 2;
    localparam int CW      = 21;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic {
        TX_IDLE, TX_BUSY
    } tx_state_e;

    // ---------------- tohost status register ----------------
    logic [63:0] tohost_q;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                  tohost_q <= '0;
        else if (bus.tohost_clr)    tohost_q <= '0;
        else if (bus.tohost_wr_en)  tohost_q <= bus.tohost_wr_data;
    end

    assign bus.tohost = tohost_q;

    // ---------------- RX path ----------------
    // NOTE: synchronizer flops reset to the idle-high line level so reset release never looks like a start bit.
    logic srx_meta, srx_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            srx_meta <= 1'b1;
            srx_sync <= 1'b1;
        end else begin
            srx_meta <= bus.srx;
            srx_sync <= srx_meta;
        end
    end

    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + CW'(1);
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!srx_sync) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = srx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {srx_sync, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d = '0;
                    if (srx_sync) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                // A held-low break must not be read as a stream of start bits.
                rx_cnt_d = '0;
                if (srx_sync) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.frame_err = frame_err_q;

    // ---------------- TX echo path ----------------
    tx_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [8:0]      tx_shift_q, tx_shift_d;
    logic            stx_q, stx_d;
    logic            tx_drop_q, tx_drop_d;
    logic            tx_go;

    assign tx_go = (LOOPBACK != 0) && rx_valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            stx_q      <= 1'b1;
            tx_drop_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            stx_q      <= stx_d;
            tx_drop_q  <= tx_drop_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        stx_d      = stx_q;
        tx_drop_d  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                stx_d = 1'b1;
                if (tx_go) begin
                    tx_state_d = TX_BUSY;
                    stx_d      = 1'b0;
                    tx_shift_d = {1'b1, rx_data_q};
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end
            end
            TX_BUSY: begin
                tx_drop_d = tx_go;
                // tx_bit_q names the bit on the line: 0 = start, 1..8 = data, 9 = stop.
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_state_d = TX_IDLE;
                        stx_d      = 1'b1;
                    end else begin
                        stx_d      = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[8:1]};
                        tx_bit_d   = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign bus.stx     = stx_q;
    assign bus.tx_drop = tx_drop_q;
endmodule

// File: tb/tb_cj_host_uart_monitor.sv
// Directed bench for cj_host_uart_monitor: one echo-enabled instance and one with
// echo disabled share the same stimulus; DIV = 10 clocks per bit.
module tb_cj_host_uart_monitor;
    localparam int CLK_HZ = 1152000;
    localparam int BAUD   = 115200;
    localparam int DIV    = 10;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        srx     = 1'b1;
    logic        wr_en   = 1'b0;
    logic        clr     = 1'b0;
    logic [63:0] wr_data = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int start_cyc = 0;
    int last_valid_cyc = 0;
    int fe_cnt = 0;
    int drop_cnt = 0;
    int nl_drop_cnt = 0;
    int nl_stx_bad = 0;
    logic [7:0] rxq[$];

    cj_host_uart_monitor_if bus_lb ();
    cj_host_uart_monitor_if bus_nl ();

    assign bus_lb.tohost_wr_en   = wr_en;
    assign bus_lb.tohost_wr_data = wr_data;
    assign bus_lb.tohost_clr     = clr;
    assign bus_lb.srx            = srx;
    assign bus_nl.tohost_wr_en   = wr_en;
    assign bus_nl.tohost_wr_data = wr_data;
    assign bus_nl.tohost_clr     = clr;
    assign bus_nl.srx            = srx;

    cj_host_uart_monitor #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .LOOPBACK(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_lb)
    );

    cj_host_uart_monitor #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .LOOPBACK(0)) dut_nl (
        .clock (clock),
        .reset (reset),
        .bus   (bus_nl)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse outputs are collected on the falling edge, half a cycle from any update.
    always @(negedge clock) begin
        if (bus_lb.rx_valid) begin
            rxq.push_back(bus_lb.rx_data);
            last_valid_cyc <= cyc;
        end
        if (bus_lb.frame_err) fe_cnt      <= fe_cnt + 1;
        if (bus_lb.tx_drop)   drop_cnt    <= drop_cnt + 1;
        if (bus_nl.tx_drop)   nl_drop_cnt <= nl_drop_cnt + 1;
        if (bus_nl.stx !== 1'b1) nl_stx_bad <= nl_stx_bad + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] q_at(input int idx);
        if (idx < rxq.size()) return 64'(rxq[idx]);
        return 64'hFFFF;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        srx = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            srx = b[i];
            repeat (DIV) tick();
        end
        srx = stop;
        repeat (DIV) tick();
    endtask

    initial begin
        int n0;
        int f0;
        int d0;
        int lat;
        int bad;
        logic [9:0] fr;
        logic [7:0] y;

        // Reset values
        repeat (3) tick();
        check("rst_tohost",    bus_lb.tohost, 64'h0);
        check("rst_stx",       64'(bus_lb.stx), 64'h1);
        check("rst_rx_valid",  64'(bus_lb.rx_valid), 64'h0);
        check("rst_rx_data",   64'(bus_lb.rx_data), 64'h0);
        check("rst_frame_err", 64'(bus_lb.frame_err), 64'h0);
        check("rst_tx_drop",   64'(bus_lb.tx_drop), 64'h0);
        check("rst_nl_stx",    64'(bus_nl.stx), 64'h1);
        reset = 1'b0;
        tick();

        // tohost: registered write, hold, clear priority
        wr_en = 1'b1; wr_data = 64'h1;
        #1;
        check("tohost_before_edge", bus_lb.tohost, 64'h0);
        tick();
        wr_en = 1'b0; wr_data = '0;
        check("tohost_wr1", bus_lb.tohost, 64'h1);
        repeat (100) tick();
        check("tohost_hold100", bus_lb.tohost, 64'h1);
        wr_en = 1'b1; wr_data = 64'hDEAD_BEEF_0000_0002;
        tick();
        wr_en = 1'b0;
        check("tohost_wr2", bus_lb.tohost, 64'hDEAD_BEEF_0000_0002);
        clr = 1'b1; wr_en = 1'b1; wr_data = 64'h5;
        tick();
        clr = 1'b0; wr_en = 1'b0; wr_data = '0;
        check("tohost_clr_prio", bus_lb.tohost, 64'h0);

        // Single byte 0x55
        n0 = rxq.size(); f0 = fe_cnt;
        send_frame(8'h55, 1'b1);
        repeat (20) tick();
        lat = last_valid_cyc - start_cyc;
        check("rx55_count", 64'(rxq.size() - n0), 64'h1);
        check("rx55_q",     q_at(n0), 64'h55);
        check("rx55_data",  64'(bus_lb.rx_data), 64'h55);
        check("rx55_latency_window", 64'((lat >= 90) && (lat <= 100)), 64'h1);
        check("rx55_no_ferr", 64'(fe_cnt - f0), 64'h0);
        repeat (100) tick();

        // 3-cycle glitch is a false start
        n0 = rxq.size(); f0 = fe_cnt;
        srx = 1'b0;
        repeat (3) tick();
        srx = 1'b1;
        repeat (30) tick();
        check("glitch_no_rx",   64'(rxq.size() - n0), 64'h0);
        check("glitch_no_ferr", 64'(fe_cnt - f0), 64'h0);

        // 0xA3 with low stop bit, line held low as a break
        send_frame(8'hA3, 1'b0);
        repeat (40) tick();
        check("ferr_pulse",     64'(fe_cnt - f0), 64'h1);
        check("ferr_no_rx",     64'(rxq.size() - n0), 64'h0);
        check("ferr_data_kept", 64'(bus_lb.rx_data), 64'h55);
        srx = 1'b1;
        repeat (20) tick();
        check("break_no_rx",   64'(rxq.size() - n0), 64'h0);
        check("break_no_ferr", 64'(fe_cnt - f0), 64'h1);
        send_frame(8'h0F, 1'b1);
        repeat (20) tick();
        check("after_break_rx", q_at(n0), 64'h0F);
        repeat (100) tick();

        // Back-to-back frames, no idle gap
        n0 = rxq.size();
        send_frame(8'h48, 1'b1);
        send_frame(8'h69, 1'b1);
        repeat (20) tick();
        check("b2b_count", 64'(rxq.size() - n0), 64'h2);
        check("b2b_first", q_at(n0), 64'h48);
        check("b2b_second", q_at(n0 + 1), 64'h69);
        repeat (120) tick();

        // Echo of 0x3C; 0x81 arrives while TX is still on the stop bit and is dropped
        n0 = rxq.size(); d0 = drop_cnt;
        fr = {1'b1, 8'h3C, 1'b0};
        fork
            begin
                send_frame(8'h3C, 1'b1);
                send_frame(8'h81, 1'b1);
            end
            begin
                int t;
                t = 0;
                while (bus_lb.stx === 1'b1 && t < 200) begin
                    tick();
                    t++;
                end
                check("tx_start_seen", 64'(bus_lb.stx), 64'h0);
                for (int k = 0; k < 10; k++) begin
                    check($sformatf("tx_bit%0d_head", k), 64'(bus_lb.stx), 64'(fr[k]));
                    repeat (9) tick();
                    check($sformatf("tx_bit%0d_tail", k), 64'(bus_lb.stx), 64'(fr[k]));
                    tick();
                end
            end
        join
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus_lb.stx !== 1'b1) bad++;
            tick();
        end
        check("tx_no_echo_after_drop", 64'(bad), 64'h0);
        check("tx_drop_once", 64'(drop_cnt - d0), 64'h1);
        check("lb_rx_count",  64'(rxq.size() - n0), 64'h2);
        repeat (100) tick();

        // Async reset during RX data bits and TX data bits
        n0 = rxq.size();
        send_frame(8'h00, 1'b1);
        y = 8'hE7;
        srx = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 3; i++) begin
            srx = y[i];
            repeat (DIV) tick();
        end
        check("tx_low_before_rst", 64'(bus_lb.stx), 64'h0);
        check("rx_first_before_rst", 64'(rxq.size() - n0), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_stx", 64'(bus_lb.stx), 64'h1);
        check("rst_async_valid", 64'(bus_lb.rx_valid), 64'h0);
        srx = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_mid_rx_data", 64'(bus_lb.rx_data), 64'h0);
        repeat (30) tick();
        check("rst_aborted_rx", 64'(rxq.size() - n0), 64'h1);
        check("rst_stx_idle",   64'(bus_lb.stx), 64'h1);
        send_frame(8'hB6, 1'b1);
        repeat (20) tick();
        check("post_rst_count", 64'(rxq.size() - n0), 64'h2);
        check("post_rst_q",     q_at(n0 + 1), 64'hB6);
        check("post_rst_data",  64'(bus_lb.rx_data), 64'hB6);
        repeat (110) tick();

        // Echo-disabled instance never drives the line or drops
        check("nl_stx_idle", 64'(nl_stx_bad), 64'h0);
        check("nl_no_drop",  64'(nl_drop_cnt), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
